ifu_fetch: RTL and testbench

Instruction fetch unit for the LA32R pipeline. It holds the fetch PC and issues requests over the SRAM-like instruction port. It buffers returned words in a 2-entry queue and presents them to the decode stage, along with the 17-bit opcode field the control unit decodes. Taken branches and jumps resolved downstream redirect it through a single redirect port; stale in-flight responses are discarded.

---
 rtl/ifu_fetch_if.sv | 25 ++
 rtl/ifu_fetch.sv | 74 +++++++
 tb/tb_ifu_fetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-port, redirect and decode-side signals of the fetch unit.
interface ifu_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [16:0] if_din;
    logic        id_ready;

    modport master (
        output inst_req, inst_addr, if_valid, if_pc, if_inst, if_din,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  inst_req, inst_addr, if_valid, if_pc, if_inst, if_din,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC, credit-limited SRAM-like requests, 2-entry instruction queue, redirect flush.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    ifu_fetch_if.master  bus
);
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  cancel_cnt_q, cancel_cnt_d;
    logic [1:0]  q_cnt_q, q_cnt_d;
    logic        q_head_q, q_head_d;
    logic        pf_head_q, pf_head_d;
    logic [31:0] q_pc_q [2];
    logic [31:0] q_inst_q [2];
    logic [31:0] pf_q [2];
    logic [2:0]  credit;
    logic        req, accept, dok, drop, push, pop;

    always_comb begin
        credit       = {1'b0, out_cnt_q} + {1'b0, q_cnt_q};
        pop          = (q_cnt_q != 2'd0) && bus.id_ready;
        req          = !cpu_rst && !bus.redirect_valid && (credit < 3'd2 || (credit == 3'd2 && pop));
        accept       = req && bus.inst_addr_ok;
        dok          = bus.inst_data_ok && (out_cnt_q != 2'd0);
        drop         = dok && (cancel_cnt_q != 2'd0 || bus.redirect_valid);
        push         = dok && !drop;
        fetch_pc_d   = bus.redirect_valid ? bus.redirect_pc : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        out_cnt_d    = out_cnt_q + 2'(accept) - 2'(dok);
        // Every request still outstanding after a redirect belongs to the old path.
        cancel_cnt_d = bus.redirect_valid ? out_cnt_q - 2'(dok)
                                          : cancel_cnt_q - 2'(dok && cancel_cnt_q != 2'd0);
        q_cnt_d      = bus.redirect_valid ? 2'd0 : q_cnt_q + 2'(push) - 2'(pop);
        q_head_d     = (pop && !bus.redirect_valid) ? ~q_head_q : q_head_q;
        pf_head_d    = dok ? ~pf_head_q : pf_head_q;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            fetch_pc_q   <= RESET_PC;
            out_cnt_q    <= 2'd0;
            cancel_cnt_q <= 2'd0;
            q_cnt_q      <= 2'd0;
            q_head_q     <= 1'b0;
            pf_head_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_pc_q[i]   <= 32'd0;
                q_inst_q[i] <= 32'd0;
                pf_q[i]     <= 32'd0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            out_cnt_q    <= out_cnt_d;
            cancel_cnt_q <= cancel_cnt_d;
            q_cnt_q      <= q_cnt_d;
            q_head_q     <= q_head_d;
            pf_head_q    <= pf_head_d;
            if (accept)
                pf_q[pf_head_q ^ out_cnt_q[0]] <= fetch_pc_q;
            if (push) begin
                q_pc_q[q_head_q ^ q_cnt_q[0]]   <= pf_q[pf_head_q];
                q_inst_q[q_head_q ^ q_cnt_q[0]] <= bus.inst_rdata;
            end
        end
    end

    assign bus.inst_req  = req;
    assign bus.inst_addr = fetch_pc_q;
    assign bus.if_valid  = q_cnt_q != 2'd0;
    assign bus.if_pc     = q_pc_q[q_head_q];
    assign bus.if_inst   = q_inst_q[q_head_q];
    assign bus.if_din    = q_inst_q[q_head_q][31:15];
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of ifu_fetch against a one-cycle in-order instruction memory.
module tb_ifu_fetch;
    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int accepts = 0;
    int acc_mark;
    bit mem_on = 1'b1;
    logic [31:0] pend [$];

    ifu_fetch_if f();
    ifu_fetch dut (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(f.master));

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        logic [31:0] e;
        e = pc ^ 32'hA5A5_0000;
        chk({tag, "_valid"}, {31'd0, f.if_valid}, 32'd1);
        chk({tag, "_pc"}, f.if_pc, pc);
        chk({tag, "_inst"}, f.if_inst, e);
        chk({tag, "_din"}, {15'd0, f.if_din}, {15'd0, e[31:15]});
    endtask

    task automatic mem_drive;
        f.inst_data_ok = mem_on && pend.size() != 0;
        f.inst_rdata   = f.inst_data_ok ? pend[0] ^ 32'hA5A5_0000 : 32'd0;
    endtask

    task automatic step;
        logic acc, dk;
        logic [31:0] a;
        #1;
        acc = f.inst_req && f.inst_addr_ok;
        a   = f.inst_addr;
        dk  = f.inst_data_ok;
        @(posedge cpu_clk);
        if (dk && pend.size() != 0) void'(pend.pop_front());
        if (acc) begin
            pend.push_back(a);
            accepts++;
        end
        @(negedge cpu_clk);
        mem_drive();
        #1;
    endtask

    task automatic do_reset;
        cpu_rst = 1'b1;
        f.redirect_valid = 1'b0;
        pend.delete();
        mem_drive();
        step();
    endtask

    initial begin
        f.inst_addr_ok = 1'b1;
        f.inst_data_ok = 1'b0;
        f.inst_rdata = 32'd0;
        f.redirect_valid = 1'b0;
        f.redirect_pc = 32'd0;
        f.id_ready = 1'b1;
        @(negedge cpu_clk);
        step();
        chk("rst_req", {31'd0, f.inst_req}, 32'd0);
        chk("rst_addr", f.inst_addr, 32'h8000_0000);
        chk("rst_valid", {31'd0, f.if_valid}, 32'd0);
        chk("rst_pc", f.if_pc, 32'd0);
        chk("rst_inst", f.if_inst, 32'd0);
        chk("rst_din", {15'd0, f.if_din}, 32'd0);

        // Streaming from reset release
        cpu_rst = 1'b0;
        #1;
        chk("first_req", {31'd0, f.inst_req}, 32'd1);
        chk("first_addr", f.inst_addr, 32'h8000_0000);
        step();
        chk("lat_valid", {31'd0, f.if_valid}, 32'd0);
        step();
        chk("first_din", {15'd0, f.if_din}, 32'h0000_4B4A);
        for (int i = 0; i < 3; i++) begin
            chk_head("stream", 32'h8000_0000 + 32'(4 * i));
            step();
        end

        // Decode stall: head holds, no new requests, order kept on release
        f.id_ready = 1'b0;
        #1;
        chk("stall_req0", {31'd0, f.inst_req}, 32'd0);
        acc_mark = accepts;
        for (int i = 0; i < 5; i++) begin
            chk_head("stall_hold", 32'h8000_000C);
            step();
        end
        chk("stall_accepts", 32'(accepts - acc_mark), 32'd0);
        chk("stall_req", {31'd0, f.inst_req}, 32'd0);
        f.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_head("release", 32'h8000_000C + 32'(4 * i));
            step();
        end

        // Redirect with two outstanding, both answered later
        do_reset();
        mem_on = 1'b0;
        cpu_rst = 1'b0;
        step();
        step();
        chk("out2_req", {31'd0, f.inst_req}, 32'd0);
        f.redirect_valid = 1'b1;
        f.redirect_pc = 32'h8000_0100;
        step();
        f.redirect_valid = 1'b0;
        chk("rd2_valid0", {31'd0, f.if_valid}, 32'd0);
        chk("rd2_addr", f.inst_addr, 32'h8000_0100);
        mem_on = 1'b1;
        mem_drive();
        step();
        chk("rd2_valid1", {31'd0, f.if_valid}, 32'd0);
        step();
        chk("rd2_valid2", {31'd0, f.if_valid}, 32'd0);
        step();
        chk_head("rd2_head", 32'h8000_0100);

        // Redirect coinciding with data_ok and pop
        do_reset();
        cpu_rst = 1'b0;
        step();
        step();
        chk("rdp_pre_valid", {31'd0, f.if_valid}, 32'd1);
        chk("rdp_pre_dok", {31'd0, f.inst_data_ok}, 32'd1);
        f.redirect_valid = 1'b1;
        f.redirect_pc = 32'h8000_0200;
        #1;
        chk("rdp_req", {31'd0, f.inst_req}, 32'd0);
        step();
        f.redirect_valid = 1'b0;
        #1;
        chk("rdp_valid", {31'd0, f.if_valid}, 32'd0);
        chk("rdp_newreq", {31'd0, f.inst_req}, 32'd1);
        chk("rdp_newaddr", f.inst_addr, 32'h8000_0200);
        step();
        chk("rdp_drop", {31'd0, f.if_valid}, 32'd0);
        step();
        chk_head("rdp_head", 32'h8000_0200);

        // Unaccepted requests, then redirect, then accept
        do_reset();
        f.inst_addr_ok = 1'b0;
        cpu_rst = 1'b0;
        acc_mark = accepts;
        for (int i = 0; i < 3; i++) begin
            chk("noack_addr", f.inst_addr, 32'h8000_0000);
            step();
        end
        f.redirect_valid = 1'b1;
        f.redirect_pc = 32'h8000_0300;
        step();
        f.redirect_valid = 1'b0;
        f.inst_addr_ok = 1'b1;
        #1;
        chk("noack_req", {31'd0, f.inst_req}, 32'd1);
        chk("noack_rdaddr", f.inst_addr, 32'h8000_0300);
        step();
        chk("noack_accepts", 32'(accepts - acc_mark), 32'd1);
        step();
        chk_head("noack_head", 32'h8000_0300);

        // Address wrap after redirect near the top of the address space
        do_reset();
        cpu_rst = 1'b0;
        f.redirect_valid = 1'b1;
        f.redirect_pc = 32'hFFFF_FFF8;
        step();
        f.redirect_valid = 1'b0;
        step();
        step();
        chk("wrap_din0", {15'd0, f.if_din}, 32'h0000_B4B5);
        chk_head("wrap0", 32'hFFFF_FFF8);
        step();
        chk_head("wrap1", 32'hFFFF_FFFC);
        step();
        chk("wrap_din2", {15'd0, f.if_din}, 32'h0001_4B4A);
        chk_head("wrap2", 32'h0000_0000);

        // Reset with one request outstanding; its late response is ignored
        do_reset();
        mem_on = 1'b0;
        cpu_rst = 1'b0;
        step();
        cpu_rst = 1'b1;
        step();
        cpu_rst = 1'b0;
        mem_on = 1'b1;
        mem_drive();
        #1;
        chk("late_dok", {31'd0, f.inst_data_ok}, 32'd1);
        chk("late_req", {31'd0, f.inst_req}, 32'd1);
        chk("late_addr", f.inst_addr, 32'h8000_0000);
        step();
        chk("late_valid", {31'd0, f.if_valid}, 32'd0);
        step();
        chk_head("late_head0", 32'h8000_0000);
        step();
        chk_head("late_head1", 32'h8000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
